// File: rtl/cp0_intc_if.sv
// cp0_intc_if: pipeline-side bus of the CP0 interrupt/exception controller
interface cp0_intc_if #(
    parameter int NUM_IRQ = 6
);
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    logic [NUM_IRQ-1:0] hw_int;
    logic [4:0]         exc_code;
    logic [31:0]        exc_pc;
    logic               exc_bd;
    logic               eret;
    logic [4:0]         cp0_addr;
    logic               cp0_we;
    logic [31:0]        cp0_wdata;
    logic [31:0]        cp0_rdata;
    logic               int_req;
    logic [IW-1:0]      irq_id;
    logic [31:0]        epc;
    logic               exl;
    modport master (
        output hw_int, exc_code, exc_pc, exc_bd, eret, cp0_addr, cp0_we, cp0_wdata,
        input  cp0_rdata, int_req, irq_id, epc, exl
    );
    modport slave (
        input  hw_int, exc_code, exc_pc, exc_bd, eret, cp0_addr, cp0_we, cp0_wdata,
        output cp0_rdata, int_req, irq_id, epc, exl
    );
endinterface

// File: rtl/cp0_intc.sv
// cp0_intc: CP0 exception/interrupt controller; define CP0_INTC_EDGE_EN for edge-mode lines (MODE/PCLR)
module cp0_intc #(
    parameter int          NUM_IRQ = 6,
    parameter logic [31:0] PRID    = 32'h0000_0700
) (
    input logic        clk,
    input logic        reset,
    cp0_intc_if.slave  bus
);
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;
    logic [NUM_IRQ-1:0] im, hw_q, ip, hit;
    logic               ie, exl_q, bd, irq, exc, take, wr, sr_wr;
    logic [4:0]         code;
    logic [31:0]        epc_q, pc_adj, sr_rd, cause_rd, mode_rd;
    logic [IW-1:0]      id;
    logic               unused_wdata;
    assign unused_wdata = ^bus.cp0_wdata;
    assign hit   = ip & im;
    assign irq   = |hit & ie & !exl_q;
    assign exc   = (bus.exc_code != 5'd0) & !exl_q;
    assign take  = irq | exc;
    assign wr    = bus.cp0_we & !take;
    assign sr_wr = wr && bus.cp0_addr == 5'd12;
    assign pc_adj = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
`ifdef CP0_INTC_EDGE_EN
    logic [NUM_IRQ-1:0] mode, pend, pclr;
    assign pclr = (wr && bus.cp0_addr == 5'd17) ? bus.cp0_wdata[NUM_IRQ-1:0] : '0;
    // Edge-mode pending latches: rising edge sets, PCLR clears, set wins a tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= '0;
            pend <= '0;
        end else begin
            if (wr && bus.cp0_addr == 5'd16) mode <= bus.cp0_wdata[NUM_IRQ-1:0];
            pend <= (pend & ~pclr) | (bus.hw_int & ~hw_q & mode);
        end
    end
    assign ip      = (mode & pend) | (~mode & hw_q);
    assign mode_rd = 32'(mode);
`else
    assign ip      = hw_q;
    assign mode_rd = '0;
`endif
    // Sample lines, enter handler on int_req, serve mtc0 and eret
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hw_q  <= '0;
            im    <= '0;
            ie    <= 1'b0;
            exl_q <= 1'b0;
            bd    <= 1'b0;
            code  <= '0;
            epc_q <= '0;
        end else begin
            hw_q  <= bus.hw_int;
            exl_q <= take ? 1'b1 : bus.eret ? 1'b0 : sr_wr ? bus.cp0_wdata[1] : exl_q;
            if (sr_wr) begin
                im <= bus.cp0_wdata[10 +: NUM_IRQ];
                ie <= bus.cp0_wdata[0];
            end
            if (take) begin
                bd    <= bus.exc_bd;
                code  <= irq ? 5'd0 : bus.exc_code;
                epc_q <= {pc_adj[31:2], 2'b00};
            end else if (wr && bus.cp0_addr == 5'd14) begin
                epc_q <= bus.cp0_wdata;
            end
        end
    end
    // Lowest-index enabled pending line wins
    always_comb begin
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (hit[i]) id = IW'(i);
    end
    // Register read mux; unimplemented bits and addresses read 0
    always_comb begin
        sr_rd = '0;
        sr_rd[10 +: NUM_IRQ] = im;
        sr_rd[1] = exl_q;
        sr_rd[0] = ie;
        cause_rd = '0;
        cause_rd[31] = bd;
        cause_rd[10 +: NUM_IRQ] = ip;
        cause_rd[6:2] = code;
        case (bus.cp0_addr)
            5'd12:   bus.cp0_rdata = sr_rd;
            5'd13:   bus.cp0_rdata = cause_rd;
            5'd14:   bus.cp0_rdata = epc_q;
            5'd15:   bus.cp0_rdata = PRID;
            5'd16:   bus.cp0_rdata = mode_rd;
            default: bus.cp0_rdata = '0;
        endcase
    end
    assign bus.int_req = take;
    assign bus.irq_id  = irq ? id : '0;
    assign bus.epc     = epc_q;
    assign bus.exl     = exl_q;
endmodule

// File: doc/cp0_intc.md
# cp0_intc

Parametrised coprocessor-0 exception and interrupt controller for the five-stage MIPS pipeline. It samples and latches `NUM_IRQ` hardware interrupt lines and supports per-channel level or edge mode. It arbitrates interrupts against the synchronous exception code presented at the M stage, saves EPC, Cause and BD, and serves `mfc0`/`mtc0` and `eret`. `int_req` is the single flush/redirect signal the pipeline consumes; the pipeline jumps to the handler when `int_req` is high.

## Interface
Parameters:
- `NUM_IRQ`, default 6: number of hardware interrupt lines; legal range 1..16.
- `PRID`, default 32'h0000_0700: constant returned by the PRId register.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `hw_int`  in  NUM_IRQ: raw hardware interrupt lines, synchronous to `clk`.
- `exc_code`  in  5: M-stage exception code; 0 means no exception.
- `exc_pc`  in  32: PC of the M-stage instruction.
- `exc_bd`  in  1: the M-stage instruction is in a branch delay slot.
- `eret`  in  1: `eret` is committing this cycle.
- `cp0_addr`  in  5: CP0 register number (`rd` field).
- `cp0_we`  in  1: `mtc0` write strobe.
- `cp0_wdata`  in  32: `mtc0` data.
- `cp0_rdata`  out  32: combinational read of `cp0_addr`.
- `int_req`  out  1: take exception or interrupt this cycle.
- `irq_id`  out  max(1,$clog2(NUM_IRQ)): index of the winning interrupt line; 0 if none.
- `epc`  out  32: current EPC, for `eret` redirection.
- `exl`  out  1: SR.EXL.

## Operation
- Register map:
  - 12 SR: IM at [9+NUM_IRQ:10], EXL at bit 1, IE at bit 0.
  - 13 Cause: BD at bit 31, IP at [9+NUM_IRQ:10] (read-only), ExcCode at [6:2].
  - 14 EPC.
  - 15 PRId.
  - 16 MODE: bit i = 1 selects edge mode for line i.
  - 17 PCLR: write-only; writing 1 to bit i clears edge-pending bit i.
  - All unimplemented bits and addresses read as 0.
- IP composition:
  - Level line: `IP[i]` is the registered `hw_int[i]`.
  - Edge line: `IP[i]` is the pending latch. The latch sets when `hw_int[i]` is high and the previous sample was low. It clears only via a PCLR write.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Interrupt condition `irq` = |(IP & IM) & IE & !EXL.
- Exception condition `exc` = (`exc_code` != 0) & !EXL.
- `int_req` = `irq` | `exc`. It is combinational from registered state and the M-stage inputs.
- Priority: an interrupt beats a simultaneous exception. Among interrupt lines, the lowest index wins and is reported on `irq_id`.
- On a clock edge with `int_req` = 1:
  - EXL <= 1.
  - BD <= `exc_bd`.
  - ExcCode <= 0 for an interrupt, otherwise `exc_code`.
  - EPC <= {(`exc_bd` ? `exc_pc`-4 : `exc_pc`)[31:2], 2'b00}.
- `mtc0` is ignored in any cycle where `int_req` = 1.
- Writes to SR, EPC, MODE and PCLR take effect on the next edge. Cause and PRId are read-only.
- `eret`: EXL <= 0 on the next edge.
- Same-cycle `eret` and `mtc0` to SR: the EXL bit comes from `eret` (0); all other SR bits come from `mtc0`.
- `cp0_rdata` always reflects pre-edge values; there is no write-through.

## Timing
- Reset values: SR, Cause, EPC, MODE, pending latches and sample flops are all 0. Hence `int_req` = 0, `irq_id` = 0, `epc` = 0, `exl` = 0.
- `hw_int` to `int_req` latency is one cycle, for both level and edge lines.
- After a level line drops, `int_req` deasserts one cycle later.
- An edge-mode pending bit persists after `hw_int` drops and persists while EXL = 1.
- `int_req` stays low for the whole time EXL = 1. Nested interrupts are not supported.
- Reset mid-handler returns EXL to 0 and loses EPC.

## Configuration
- `CP0_INTC_EDGE_EN` defined: MODE register, pending latches and PCLR are compiled in.
- `CP0_INTC_EDGE_EN` undefined:
  - All lines are level mode.
  - Addresses 16 and 17 read 0; writes to them are ignored.
  - No pending or edge flops are synthesised.

## Test plan
- Level interrupt, `NUM_IRQ` = 6:
  - Stimulus: after reset, `mtc0` SR = 32'h0000_0C01 (IM bits 0 and 1, IE set). Raise `hw_int` = 6'b000010 with `exc_pc` = 32'h3000.
  - Response: `int_req` = 1 one cycle later, `irq_id` = 1.
  - Next edge: `exl` = 1, Cause = 32'h0000_0800, EPC = 32'h3000.
- Delay slot:
  - Stimulus: `exc_code` = 12 (Ov), `exc_bd` = 1, `exc_pc` = 32'h3010, SR = 1.
  - Response: Cause = 32'h8000_0030, EPC = 32'h300C.
- Priority:
  - Stimulus: `hw_int` bits 3 and 5 are enabled and asserted while `exc_code` = 4.
  - Response: `irq_id` = 3, ExcCode = 0.
- `eret` / `mtc0` collision:
  - Stimulus: with EXL = 1, assert `eret` and `mtc0` SR = 32'h0000_FC03 in the same cycle.
  - Response: SR reads 32'h0000_FC01 and `exl` = 0.
- Edge mode (`CP0_INTC_EDGE_EN` defined):
  - Stimulus: MODE = 1, pulse `hw_int[0]` for one cycle.
  - Response: IP[0] stays 1 after the pulse and clears only after a PCLR write of 1.
- Asynchronous reset:
  - Stimulus: pull `reset` low mid-cycle while EXL = 1.
  - Response: `exl`, `epc`, `int_req` and `irq_id` read 0 immediately, without waiting for a clock edge.
